// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder/subtractor.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// Request/response bundle of the serial adder: operands in, handshake and result out.
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, sub, a, b, cin,
    input  ready, busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, sub, a, b, cin,
    output ready, busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/serial_adder_fa_cell.sv
// Single combinational full-adder cell shared by every bit position.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one bit per cycle, LSB first, through one full adder.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_c;

  fa_cell u_fa (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .cin (carry),
    .sum (fa_s),
    .cout(fa_c)
  );

  // Result bits enter a_sh from the top as operand bits leave the bottom,
  // so sum only ever sees the fully assembled word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      a_sh         <= '0;
      b_sh         <= '0;
      carry        <= 1'b0;
      cnt          <= '0;
      bus.ready    <= 1'b1;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.sum      <= '0;
      bus.cout     <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state     <= RUN;
            bus.ready <= 1'b0;
            bus.busy  <= 1'b1;
            a_sh      <= bus.a;
            b_sh      <= bus.sub ? ~bus.b : bus.b;
            carry     <= bus.sub | bus.cin;
            cnt       <= '0;
          end
        end
        RUN: begin
          a_sh  <= {fa_s, a_sh[WIDTH-1:1]};
          b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
          carry <= fa_c;
          if (cnt == CW'(WIDTH-1)) begin
            state        <= DONE;
            bus.busy     <= 1'b0;
            bus.sum      <= {fa_s, a_sh[WIDTH-1:1]};
            bus.cout     <= fa_c;
            // carry still holds the carry into the MSB here
            bus.overflow <= carry ^ fa_c;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          state     <= IDLE;
          bus.ready <= 1'b1;
          bus.done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: stimulus pushes model results, a monitor pops on done.
module tb_serial_adder;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           k;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t q[$];
  logic [W-1:0] last_sum = '0;
  int   busy_cnt = 0;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain unsigned/signed arithmetic on whole words.
  function automatic exp_t model(input logic [W-1:0] a, b, input logic cin, sub);
    exp_t   e;
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint sr;
    int unsigned full;
    if (sub) begin
      full   = int'(a) - int'(b);
      e.sum  = full[W-1:0];
      e.cout = (int'(a) >= int'(b));
      sr     = sa - sb;
    end else begin
      full   = int'(a) + int'(b) + int'(cin);
      e.sum  = full[W-1:0];
      e.cout = (full > 255);
      sr     = sa + sb + longint'(cin);
    end
    e.ovf = (sr > 127) || (sr < -128);
    e.k   = 0;
    return e;
  endfunction

  task automatic issue(input logic [W-1:0] a, b, input logic cin, sub);
    exp_t e;
    int   t = 0;
    @(negedge clk);
    while (!bus.ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.ready) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    bus.start = 1'b1;
    bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub;
    e = model(a, b, cin, sub);
    @(negedge clk);
    e.k = cyc;
    q.push_back(e);
    // scramble inputs after acceptance; the op in flight must not notice
    bus.start = 1'b0;
    bus.a = W'($urandom); bus.b = W'($urandom);
    bus.cin = 1'($urandom); bus.sub = 1'($urandom);
  endtask

  // Monitor: result hold during RUN, busy length, latency and value on done.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.busy) begin
          busy_cnt++;
          chk("sum_held_in_run", bus.sum, last_sum);
        end
        if (bus.done) begin
          if (q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = q.pop_front();
            chk("sum", bus.sum, e.sum);
            chk("cout", bus.cout, e.cout);
            chk("overflow", bus.overflow, e.ovf);
            // start sampled at edge k, done visible after edge k+W+1
            chk("latency", cyc - e.k, W + 1);
            chk("busy_cycles", busy_cnt, W);
          end
          busy_cnt = 0;
          last_sum = bus.sum;
        end
      end
    end
  end

  initial begin
    int t;
    bus.start = 1'b0; bus.sub = 1'b0; bus.cin = 1'b0;
    bus.a = '0; bus.b = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", bus.ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_sum", bus.sum, 0);
    chk("rst_cout", bus.cout, 0);
    chk("rst_ovf", bus.overflow, 0);
    rst = 1'b0;

    // directed corner cases, issued back to back
    issue(8'hFF, 8'h01, 1'b0, 1'b0);
    issue(8'h7F, 8'h01, 1'b0, 1'b0);
    issue(8'h05, 8'h07, 1'b0, 1'b1);
    issue(8'h07, 8'h05, 1'b1, 1'b1);
    issue(8'h80, 8'h01, 1'b0, 1'b1);
    issue(8'hFF, 8'hFF, 1'b1, 1'b0);

    // start while busy must be ignored
    issue(8'h3C, 8'h21, 1'b1, 1'b0);
    bus.start = 1'b1; bus.a = 8'h11; bus.b = 8'h11;
    repeat (3) @(negedge clk);
    chk("busy_during_ignored_start", bus.busy, 1);
    bus.start = 1'b0;

    // reset in RUN cycle 4, with start held high in the same cycle
    issue(8'h55, 8'h0F, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("run_before_abort", bus.busy, 1);
    rst = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    q.delete();
    last_sum = '0;
    busy_cnt = 0;
    chk("abort_ready", bus.ready, 1);
    chk("abort_busy", bus.busy, 0);
    chk("abort_sum", bus.sum, 0);
    chk("abort_done", bus.done, 0);
    rst = 1'b0; bus.start = 1'b0;
    repeat (12) @(negedge clk);
    chk("idle_after_abort", bus.ready, 1);
    issue(8'h55, 8'h0F, 1'b0, 1'b0);

    // random sweep in both modes
    for (int i = 0; i < 40; i++)
      issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));

    t = 0;
    while (q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("queue_drained", q.size(), 0);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
